uart_tx: RTL and testbench

- UART transmitter: serialises 8-bit bytes as 8N1 frames on TX (optional even parity), LSB first.
- Uses the same oversampling clock-enable tick (CLK_EN, 16x baud by default) as the UART receive path, so both directions share one baud generator.
- One-deep holding register allows the next byte to be queued while a frame is shifting, giving back-to-back frames with no idle gap.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter driven by the shared oversample tick CLK_EN.
// A one-deep holding register lets the next byte queue behind the frame on the
// line, so frames can run back to back with no idle gap.
// Optional even parity bit: define UART_TX_PARITY_EN.
module uart_tx #(
  parameter int unsigned OVERSAMPLE = 16,  // CLK_EN ticks per bit (2..256)
  parameter int unsigned STOP_BITS  = 1    // 1 or 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLK_EN,
  input  logic [7:0] DATA,
  input  logic       WR_EN,
  output logic       BUSY,
  output logic       TX_ACTIVE,
  output logic       DONE,
  output logic       TX
);

  localparam int unsigned STOP_TICKS = OVERSAMPLE * STOP_BITS;
  localparam int unsigned CNT_W      = $clog2(STOP_TICKS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_TICKS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_sample;
  logic [2:0]       r_bit;
  logic [7:0]       r_hold;
  logic [7:0]       r_shift;
  logic             r_busy;
  logic             r_active;
  logic             r_done;
  logic             r_tx;
`ifdef UART_TX_PARITY_EN
  logic             r_par;
`endif

  logic w_accept;
  logic w_bit_end;
  logic w_stop_end;
  logic w_load;

  assign w_accept   = WR_EN & ~r_busy;
  assign w_bit_end  = (r_sample == BIT_LAST);
  assign w_stop_end = (r_sample == STOP_LAST);
  // Holding -> shift happens from IDLE, or on the last stop tick for back-to-back frames.
  assign w_load     = CLK_EN & r_busy &
                      ((r_state == S_IDLE) | ((r_state == S_STOP) & w_stop_end));

  // Write acceptance, frame sequencing and registered line/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_bit    <= '0;
      r_hold   <= '0;
      r_shift  <= '0;
      r_busy   <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_hold <= DATA;
        r_busy <= 1'b1;
      end
      if (CLK_EN) begin
        case (r_state)
          S_IDLE: begin
            r_tx <= 1'b1;
          end
          S_START: begin
            if (w_bit_end) begin
              r_state  <= S_DATA;
              r_tx     <= r_shift[0];
              r_bit    <= '0;
              r_sample <= '0;
            end else begin
              r_sample <= r_sample + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (w_bit_end) begin
              r_sample <= '0;
              if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                r_state <= S_PARITY;
                r_tx    <= r_par;
`else
                r_state <= S_STOP;
                r_tx    <= 1'b1;
`endif
              end else begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {1'b0, r_shift[7:1]};
                r_tx    <= r_shift[1];
              end
            end else begin
              r_sample <= r_sample + CNT_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (w_bit_end) begin
              r_state  <= S_STOP;
              r_tx     <= 1'b1;
              r_sample <= '0;
            end else begin
              r_sample <= r_sample + CNT_W'(1);
            end
          end
`endif
          S_STOP: begin
            if (w_stop_end) begin
              r_done   <= 1'b1;
              r_sample <= '0;
              r_state  <= S_IDLE;
              r_active <= 1'b0;
              r_tx     <= 1'b1;
            end else begin
              r_sample <= r_sample + CNT_W'(1);
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
            r_tx     <= 1'b1;
            r_sample <= '0;
            r_bit    <= '0;
          end
        endcase
        // Loading overrides the IDLE/STOP assignments above on the same tick.
        if (w_load) begin
          r_shift  <= r_hold;
`ifdef UART_TX_PARITY_EN
          r_par    <= ^r_hold;
`endif
          r_busy   <= 1'b0;
          r_tx     <= 1'b0;
          r_sample <= '0;
          r_state  <= S_START;
          r_active <= 1'b1;
        end
      end
    end
  end

  assign BUSY      = r_busy;
  assign TX_ACTIVE = r_active;
  assign DONE      = r_done;
  assign TX        = r_tx;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx; adapts frame layout when UART_TX_PARITY_EN is set.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int SB  = 2;
  localparam int PAR = 1;
`else
  localparam int SB  = 1;
  localparam int PAR = 0;
`endif
  localparam int OS = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLK_EN;
  logic [7:0] DATA;
  logic       WR_EN;
  logic       BUSY, TX_ACTIVE, DONE, TX;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int en_div  = 1;

  uart_tx #(.OVERSAMPLE(OS), .STOP_BITS(SB)) dut (
    .CLK(CLK), .RST(RST), .CLK_EN(CLK_EN), .DATA(DATA), .WR_EN(WR_EN),
    .BUSY(BUSY), .TX_ACTIVE(TX_ACTIVE), .DONE(DONE), .TX(TX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Advance to the next negedge; inputs set here are seen at the next posedge.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    CLK_EN = ((cyc % en_div) == 0);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR == 1 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    DATA  = b;
    WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic wait_fall(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (TX === 1'b0) break;
      tick();
    end
    chk("tx_fall_timeout", TX, 1'b0);
  endtask

  // Called on the negedge right after TX fell; returns at index 'total'.
  task automatic check_frame(input logic [7:0] b, input int period, input logic more,
                             input int w1, input logic [7:0] b1,
                             input int w2, input logic [7:0] b2);
    int total;
    total = (9 + SB + PAR) * period;
    for (int c = 0; c < total; c++) begin
      chk($sformatf("tx_%02h_c%0d", b, c), TX, exp_bit(b, c / period));
      chk($sformatf("active_%02h_c%0d", b, c), TX_ACTIVE, 1'b1);
      if (c > 0) chk($sformatf("done_lo_%02h_c%0d", b, c), DONE, 1'b0);
      WR_EN = (c == w1) || (c == w2);
      DATA  = (c == w1) ? b1 : b2;
      tick();
    end
    WR_EN = 1'b0;
    chk($sformatf("done_hi_%02h", b), DONE, 1'b1);
    chk($sformatf("active_end_%02h", b), TX_ACTIVE, more);
    chk($sformatf("tx_end_%02h", b), TX, ~more);
  endtask

  task automatic check_idle(input string tag);
    tick();
    chk({tag, "_tx"}, TX, 1'b1);
    chk({tag, "_active"}, TX_ACTIVE, 1'b0);
    chk({tag, "_done"}, DONE, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    RST = 1'b1; CLK_EN = 1'b0; WR_EN = 1'b0; DATA = 8'h00;
    tick();
    chk("rst_tx", TX, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_active", TX_ACTIVE, 1'b0);
    chk("rst_done", DONE, 1'b0);
    RST = 1'b0;
    tick(); tick();

    // Single frame from idle, CLK_EN every cycle; BUSY high for one cycle.
    write_byte(8'hA5);
    chk("a5_busy_set", BUSY, 1'b1);
    chk("a5_tx_hi", TX, 1'b1);
    wait_fall(4);
    chk("a5_busy_clr", BUSY, 1'b0);
    check_frame(8'hA5, OS, 1'b0, -1, 8'h00, -1, 8'h00);
    check_idle("a5_idle");

    // Back-to-back: 0x0F queued while 0x55 shifts.
    write_byte(8'h55);
    wait_fall(4);
    check_frame(8'h55, OS, 1'b1, 20, 8'h0F, -1, 8'h00);
    check_frame(8'h0F, OS, 1'b0, -1, 8'h00, -1, 8'h00);
    check_idle("0f_idle");

    // Holding full with 0x22: the 0x11 write is dropped.
    write_byte(8'h44);
    wait_fall(4);
    check_frame(8'h44, OS, 1'b1, 10, 8'h22, 30, 8'h11);
    check_frame(8'h22, OS, 1'b0, -1, 8'h00, -1, 8'h00);
    check_idle("22_idle");
    for (int i = 0; i < 40; i++) tick();
    chk("no_11_tx", TX, 1'b1);
    chk("no_11_active", TX_ACTIVE, 1'b0);

    // CLK_EN one cycle in three: every bit lasts 3*OS clocks.
    en_div = 3;
    write_byte(8'h80);
    wait_fall(8);
    check_frame(8'h80, 3 * OS, 1'b0, -1, 8'h00, -1, 8'h00);
    check_idle("80_idle");
    en_div = 1;
    tick();

    // Async reset during data bit 3 with a byte queued.
    write_byte(8'h96);
    wait_fall(4);
    for (int c = 0; c < OS + 3 * OS + 5; c++) begin
      WR_EN = (c == 5);
      DATA  = 8'h3C;
      tick();
    end
    WR_EN = 1'b0;
    chk("pre_rst_tx_bit3", TX, 1'b0);
    chk("pre_rst_busy", BUSY, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("arst_tx", TX, 1'b1);
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_active", TX_ACTIVE, 1'b0);
    tick();
    RST = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      chk($sformatf("post_rst_tx_c%0d", c), TX, 1'b1);
      chk($sformatf("post_rst_done_c%0d", c), DONE, 1'b0);
      chk($sformatf("post_rst_active_c%0d", c), TX_ACTIVE, 1'b0);
    end

    // Byte with three ones: parity bit 1 when enabled.
    write_byte(8'h07);
    wait_fall(4);
    check_frame(8'h07, OS, 1'b0, -1, 8'h00, -1, 8'h00);
    check_idle("07_idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
